// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 trigger/echo ranging to whole centimetres and a 3-bit note band (optional MEDIAN3_EN median-of-three filter)
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int DIST_W         = 9,
  parameter int NOTE_BASE_CM   = 5,
  parameter int BAND_CM        = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance_cm,
  output logic [2:0]        note,
  output logic              hand_present,
  output logic              sample_valid,
  output logic              timeout
);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLD} state_t;
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(CYCLES_PER_CM + 1);
  localparam logic [DIST_W-1:0] D_MAX = '1;
  state_t            state_q, state_d;
  logic [PW-1:0]     per_q, per_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [SW-1:0]     sub_q, sub_d;
  logic [DIST_W-1:0] cm_q, cm_d, dist_q, dist_d, raw, filt;
  logic [2:0]        echo_q, echo_d, note_q, note_d, band_note;
  logic              tof_q, tof_d, hand_q, hand_d, valid_q, valid_d, tout_q, tout_d;
  logic              rise, fall, tmo_end, sub_end, filt_ovr, band_hand;
  assign rise    = echo_q[1] & ~echo_q[2];
  assign fall    = ~echo_q[1] & echo_q[2];
  assign tmo_end = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign sub_end = sub_q == SW'(CYCLES_PER_CM - 1);
  assign raw     = tof_q ? D_MAX : cm_q;
`ifdef MEDIAN3_EN
  logic [DIST_W-1:0] h0_q, h0_d, h1_q, h1_d;
  function automatic logic [DIST_W-1:0] med3(input logic [DIST_W-1:0] a, b, c);
    logic [DIST_W-1:0] lo, hi;
    lo = a < b ? a : b;
    hi = a < b ? b : a;
    return c < lo ? lo : (c > hi ? hi : c);
  endfunction
  assign filt     = med3(raw, h0_q, h1_q);
  assign filt_ovr = 1'b0;
  // Shift the raw distance into the two-deep history once per completed sample
  always_comb begin
    h0_d = state_q == DONE ? raw : h0_q;
    h1_d = state_q == DONE ? h0_q : h1_q;
  end
  // History register, cleared by reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      h0_q <= '0;
      h1_q <= '0;
    end else begin
      h0_q <= h0_d;
      h1_q <= h1_d;
    end
  end
`else
  assign filt     = raw;
  assign filt_ovr = tof_q;
`endif
  // Comparator chain mapping the reported distance onto the eight note bands
  always_comb begin
    band_note = '0;
    for (int k = 1; k < 8; k++)
      band_note = (32'(filt) >= 32'(NOTE_BASE_CM + k * BAND_CM)) ? 3'(k) : band_note;
    band_hand = !filt_ovr && 32'(filt) >= 32'(NOTE_BASE_CM) && 32'(filt) < 32'(NOTE_BASE_CM + 8 * BAND_CM);
  end
  // Ranging FSM: trigger, wait for echo, count centimetres, publish, hold out the period
  always_comb begin
    state_d = state_q;
    per_d   = state_q == IDLE ? per_q : (per_q == PW'(PERIOD_CYCLES - 1) ? '0 : per_q + 1'b1);
    tmo_d   = tmo_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    tof_d   = tof_q;
    echo_d  = {echo_q[1:0], echo};
    dist_d  = dist_q;
    note_d  = note_q;
    hand_d  = hand_q;
    tout_d  = tout_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = enable ? TRIG : IDLE;
        per_d   = '0;
      end
      TRIG: begin
        tmo_d   = '0;
        sub_d   = '0;
        cm_d    = '0;
        tof_d   = 1'b0;
        state_d = per_q == PW'(TRIG_CYCLES - 1) ? WAIT_RISE : TRIG;
      end
      WAIT_RISE: begin
        tmo_d   = tmo_q + 1'b1;
        state_d = rise ? MEASURE : (tmo_end ? DONE : WAIT_RISE);
        tof_d   = !rise && tmo_end;
      end
      MEASURE: begin
        tmo_d   = tmo_q + 1'b1;
        sub_d   = sub_end ? '0 : sub_q + 1'b1;
        cm_d    = (sub_end && cm_q != D_MAX) ? cm_q + 1'b1 : cm_q;
        state_d = (fall || tmo_end) ? DONE : MEASURE;
        tof_d   = !fall && tmo_end;
      end
      DONE: begin
        state_d = HOLD;
        valid_d = 1'b1;
        dist_d  = filt;
        hand_d  = band_hand;
        note_d  = band_hand ? band_note : '0;
        tout_d  = tof_q;
      end
      HOLD: begin
        state_d = per_q == PW'(PERIOD_CYCLES - 1) ? (enable ? TRIG : IDLE) : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  // State, counters, synchroniser and output registers; reset aborts at once
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      per_q   <= '0;
      tmo_q   <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      tof_q   <= 1'b0;
      echo_q  <= '0;
      dist_q  <= '0;
      note_q  <= '0;
      hand_q  <= 1'b0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tmo_q   <= tmo_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
      tof_q   <= tof_d;
      echo_q  <= echo_d;
      dist_q  <= dist_d;
      note_q  <= note_d;
      hand_q  <= hand_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end
  assign trig         = state_q == TRIG;
  assign distance_cm  = dist_q;
  assign note         = note_q;
  assign hand_present = hand_q;
  assign sample_valid = valid_q;
  assign timeout      = tout_q;
endmodule
